muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, directly downstream of the decode→execute pipeline register bank. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO with operands taken from the pipeline register outputs. Holds the architectural HI and LO registers. Raises `busy` so the hazard logic can stall MFHI/MFLO and new mult/div issues until a result is committed.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg
// Operation codes and FSM state encoding shared by the multiply/divide unit
// and the decode stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] c_op_mult  = 3'd0;
  localparam logic [2:0] c_op_multu = 3'd1;
  localparam logic [2:0] c_op_div   = 3'd2;
  localparam logic [2:0] c_op_divu  = 3'd3;
  localparam logic [2:0] c_op_mthi  = 3'd4;
  localparam logic [2:0] c_op_mtlo  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step
// One iteration of shift-add multiply or restoring divide on the accumulator.
// Divide half present only when MULDIV_DIV_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   operand,
`ifdef MULDIV_DIV_EN
  input  logic                is_div,
`endif
  output logic [2*DATA_W-1:0] acc_next,
  output logic                q_bit
);

  logic [DATA_W:0] w_sum;

  // Multiplier bit sits in acc[0]; the carry rides into the shifted upper half.
  assign w_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0] w_rem_sh;
  logic [DATA_W:0] w_diff;

  assign w_rem_sh = acc[2*DATA_W-1:DATA_W-1];
  assign w_diff   = w_rem_sh - {1'b0, operand};

  always_comb begin
    acc_next = {w_sum, acc[DATA_W-1:1]};
    q_bit    = 1'b0;
    if (is_div) begin
      q_bit    = ~w_diff[DATA_W];
      acc_next = {(w_diff[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0]),
                  acc[DATA_W-2:0], 1'b0};
    end
  end
`else
  assign acc_next = {w_sum, acc[DATA_W-1:1]};
  assign q_bit    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// Iterative multiply/divide unit holding HI/LO; divide datapath built only
// when MULDIV_DIV_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int                 c_cnt_w = $clog2(DATA_W + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W - 1);

  state_t              r_state;
  logic [2:0]          r_op;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_operand;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_busy;
  logic                r_done;

  logic                w_signed_op;
  logic                w_sign_a;
  logic                w_sign_b;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_run_mul;
  logic                w_neg;
  logic [2*DATA_W-1:0] w_product;
  logic [2*DATA_W-1:0] w_acc_next;
  logic                w_q_bit;

  assign w_signed_op = (op == c_op_mult) || (op == c_op_div);
  assign w_sign_a    = w_signed_op & operand_a[DATA_W-1];
  assign w_sign_b    = w_signed_op & operand_b[DATA_W-1];
  assign w_mag_a     = w_sign_a ? -operand_a : operand_a;
  assign w_mag_b     = w_sign_b ? -operand_b : operand_b;

  assign w_run_mul = (r_op == c_op_mult) || (r_op == c_op_multu);
  assign w_neg     = r_sign_a ^ r_sign_b;
  assign w_product = w_neg ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic              r_b_zero;
  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_rem;

  // Divide by zero leaves |a| as remainder, so sign correction restores a.
  assign w_quot = r_b_zero ? '1 : (w_neg ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
  assign w_rem  = r_sign_a ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
`endif

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .acc      (r_acc),
    .operand  (r_operand),
`ifdef MULDIV_DIV_EN
    .is_div   (~w_run_mul),
`endif
    .acc_next (w_acc_next),
    .q_bit    (w_q_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_acc     <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_b_zero  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              c_op_mult, c_op_multu: begin
                r_op      <= op;
                r_sign_a  <= w_sign_a;
                r_sign_b  <= w_sign_b;
                r_acc     <= {{DATA_W{1'b0}}, w_mag_b};
                r_operand <= w_mag_a;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_state   <= ST_RUN;
              end
              c_op_div, c_op_divu: begin
                r_op     <= op;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_busy   <= 1'b1;
`ifdef MULDIV_DIV_EN
                r_acc     <= {{DATA_W{1'b0}}, w_mag_a};
                r_operand <= w_mag_b;
                r_b_zero  <= (operand_b == '0);
                r_cnt     <= '0;
                r_state   <= ST_RUN;
`else
                r_state   <= ST_FINISH;
`endif
              end
              c_op_mthi: r_hi <= operand_a;
              c_op_mtlo: r_lo <= operand_a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Quotient bit fills the slot vacated by the divide shift.
          r_acc <= {w_acc_next[2*DATA_W-1:1], w_acc_next[0] | w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (w_run_mul) begin
            {r_hi, r_lo} <= w_product;
          end
`ifdef MULDIV_DIV_EN
          else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed table, random ops against an
// arithmetic reference model, and reset during an operation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DATA_W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit c_div_en = 1'b1;
`else
  localparam bit c_div_en = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  muldiv_unit #(.DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          keep_hi;
    bit          keep_lo;
    bit          poke;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic bit is_div_op(input logic [2:0] o);
    return (o == c_op_div) || (o == c_op_divu);
  endfunction

  // Architectural result of one op, from plain integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      c_op_mult:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      c_op_multu: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      c_op_div, c_op_divu: begin
        if (c_div_en) begin
          if (b == 32'h0) begin
            l = '1;
            h = a;
          end else if (o == c_op_div) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
          end else begin
            l = a / b;
            h = a % b;
          end
        end
      end
      c_op_mthi: h = a;
      c_op_mtlo: l = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit poke);
    int nb;
    int exp_busy;
    int bad;
    if (o == c_op_mult || o == c_op_multu) exp_busy = DATA_W + 1;
    else if (is_div_op(o))                 exp_busy = c_div_en ? DATA_W + 1 : 1;
    else                                   exp_busy = 0;
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(negedge clock);
    start     = 1'b0;
    op        = 3'($urandom_range(0, 5));
    operand_a = $urandom;
    operand_b = $urandom;
    nb  = 0;
    bad = 0;
    while (busy === 1'b1 && nb < 200) begin
      if (done !== 1'b0) bad++;
      if (hi !== m_hi || lo !== m_lo) bad++;
      start = poke && (nb == 3);
      nb++;
      @(negedge clock);
    end
    start = 1'b0;
    check({name, " busy cycles"}, 32'(nb), 32'(exp_busy));
    check({name, " done"}, {31'b0, done}, 32'(exp_busy != 0));
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    if (exp_busy != 0) check({name, " hold"}, 32'(bad), 32'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vecs[12];

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          cnt;

    vecs[0]  = '{"mult_neg2x3",   c_op_mult,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 0};
    vecs[1]  = '{"multu_max",     c_op_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0};
    vecs[2]  = '{"div_m7_2",      c_op_div,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0};
    vecs[3]  = '{"divu_by0",      c_op_divu,  32'h1234,     32'h0,        32'h00001234, 32'hFFFFFFFF, 0, 0, 0};
    vecs[4]  = '{"div_ovf",       c_op_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 0};
    vecs[5]  = '{"mthi",          c_op_mthi,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1, 0};
    vecs[6]  = '{"mult_ignored",  c_op_mult,  32'h7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 0, 0, 1};
    vecs[7]  = '{"mtlo_b2b",      c_op_mtlo,  32'h55AA55AA, 32'h0,        32'h0,        32'h55AA55AA, 1, 0, 0};
    vecs[8]  = '{"multu_zero",    c_op_multu, 32'h0,        32'd12345,    32'h0,        32'h0,        0, 0, 0};
    vecs[9]  = '{"div_m7_m2",     c_op_div,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0, 0, 0};
    vecs[10] = '{"div_min_by0",   c_op_div,   32'h80000000, 32'h0,        32'h80000000, 32'hFFFFFFFF, 0, 0, 0};
    vecs[11] = '{"divu_100_3",    c_op_divu,  32'd100,      32'd3,        32'h00000001, 32'h00000021, 0, 0, 0};

    reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clock);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      eh = vecs[i].keep_hi ? m_hi : vecs[i].exp_hi;
      el = vecs[i].keep_lo ? m_lo : vecs[i].exp_lo;
      if (is_div_op(vecs[i].op) && !c_div_en) begin
        eh = m_hi;
        el = m_lo;
      end
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, eh, el, vecs[i].poke);
    end

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      eh = m_hi;
      el = m_lo;
      model(o, a, b, eh, el);
      run_op($sformatf("rand%0d", i), o, a, b, eh, el, 1'b0);
    end

    run_op("pre_mthi", c_op_mthi, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, m_lo, 1'b0);
    run_op("pre_mtlo", c_op_mtlo, 32'h5A5A5A5A, 32'h0, m_hi, 32'h5A5A5A5A, 1'b0);
    start     = 1'b1;
    op        = c_div_en ? c_op_divu : c_op_multu;
    operand_a = 32'd100;
    operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("midop busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    check("midreset busy", {31'b0, busy}, 32'h0);
    check("midreset done", {31'b0, done}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) cnt++;
    end
    check("after reset quiet", 32'(cnt), 32'h0);
    check("after reset hi", hi, 32'h0);
    check("after reset lo", lo, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
